// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg -- configurable inter-stage pipeline register (D/E, E/M, M/W)
//
// Captures an instruction's PC, write-back control, destination GPR, Tnew
// hazard counter, an opaque control bundle and DATA_N data lanes. It supports
// stall (hold), flush (bubble) and an optional saturating Tnew countdown. It
// also presents a registered forwarding-ready view to the hazard unit.
//
// Per-edge priority: reset > flush > stall > load. Reset is synchronous and
// active-high.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   stall, flush        hold state / load a bubble this edge
//   valid_in            upstream slot holds a real instruction
//   pc_in, reg_write_in, reg_dst_in, tnew_in, ctrl_in, data_in
//                       upstream fields; lane k at data_in[k*DATA_W +: DATA_W]
//   valid_out, pc_out, reg_write_out, reg_dst_out, tnew_out, ctrl_out, data_out
//                       registered fields
//   fwd_ready           valid & writes a non-zero GPR & result already available
//
// Optional feature (macro PIPE_PERF_CNT_EN):
//   perf_stall_cnt      saturating count of stalled (non-flushed) edges
//   perf_bubble_cnt     saturating count of edges that load a bubble
module pipe_stage_reg #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned DATA_N   = 2,
    parameter int unsigned CTRL_W   = 4,
    parameter int unsigned TNEW_W   = 2,
    parameter int unsigned TNEW_DEC = 1,
    parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     stall,
    input  logic                     flush,
    input  logic                     valid_in,
    input  logic [31:0]              pc_in,
    input  logic                     reg_write_in,
    input  logic [4:0]               reg_dst_in,
    input  logic [TNEW_W-1:0]        tnew_in,
    input  logic [CTRL_W-1:0]        ctrl_in,
    input  logic [DATA_N*DATA_W-1:0] data_in,
    output logic                     valid_out,
    output logic [31:0]              pc_out,
    output logic                     reg_write_out,
    output logic [4:0]               reg_dst_out,
    output logic [TNEW_W-1:0]        tnew_out,
    output logic [CTRL_W-1:0]        ctrl_out,
    output logic [DATA_N*DATA_W-1:0] data_out,
`ifdef PIPE_PERF_CNT_EN
    output logic [15:0]              perf_stall_cnt,
    output logic [15:0]              perf_bubble_cnt,
`endif
    output logic                     fwd_ready
);

    logic [TNEW_W-1:0] tnew_next;

    // Saturating decrement: an already-available result stays at 0.
    generate
        if (TNEW_DEC != 0) begin : g_tnew_dec
            always_comb begin
                tnew_next = '0;
                if (tnew_in != '0)
                    tnew_next = tnew_in - TNEW_W'(1);
            end
        end else begin : g_tnew_pass
            always_comb begin
                tnew_next = tnew_in;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_out     <= 1'b0;
            pc_out        <= PC_RESET;
            reg_write_out <= 1'b0;
            reg_dst_out   <= '0;
            tnew_out      <= '0;
            ctrl_out      <= '0;
            data_out      <= '0;
        end else if (flush || (!stall && !valid_in)) begin
            // Bubble keeps the incoming PC for exception reporting.
            valid_out     <= 1'b0;
            pc_out        <= pc_in;
            reg_write_out <= 1'b0;
            reg_dst_out   <= '0;
            tnew_out      <= '0;
            ctrl_out      <= '0;
            data_out      <= '0;
        end else if (!stall) begin
            valid_out     <= 1'b1;
            pc_out        <= pc_in;
            // Writes to $0 are never advertised.
            reg_write_out <= reg_write_in && (reg_dst_in != 5'd0);
            reg_dst_out   <= reg_dst_in;
            tnew_out      <= tnew_next;
            ctrl_out      <= ctrl_in;
            data_out      <= data_in;
        end
    end

    assign fwd_ready = valid_out && reg_write_out && (reg_dst_out != 5'd0)
                       && (tnew_out == '0);

`ifdef PIPE_PERF_CNT_EN
    logic stall_evt;
    logic bubble_evt;

    assign stall_evt  = stall && !flush;
    assign bubble_evt = flush || (!stall && !valid_in);

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_cnt  <= '0;
            perf_bubble_cnt <= '0;
        end else begin
            if (stall_evt && (perf_stall_cnt != 16'hFFFF))
                perf_stall_cnt <= perf_stall_cnt + 16'd1;
            if (bubble_evt && (perf_bubble_cnt != 16'hFFFF))
                perf_bubble_cnt <= perf_bubble_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed, table-driven bench for pipe_stage_reg (default parameters), plus
// a TNEW_DEC=0 instance and, when PIPE_PERF_CNT_EN is defined, counter checks.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        reset, stall, flush, valid_in, reg_write_in;
    logic [31:0] pc_in;
    logic [4:0]  reg_dst_in;
    logic [1:0]  tnew_in;
    logic [3:0]  ctrl_in;
    logic [63:0] data_in;

    logic        valid_out, reg_write_out, fwd_ready;
    logic [31:0] pc_out;
    logic [4:0]  reg_dst_out;
    logic [1:0]  tnew_out;
    logic [3:0]  ctrl_out;
    logic [63:0] data_out;

    logic        nd_valid_out, nd_reg_write_out, nd_fwd_ready;
    logic [31:0] nd_pc_out;
    logic [4:0]  nd_reg_dst_out;
    logic [1:0]  nd_tnew_out;
    logic [3:0]  nd_ctrl_out;
    logic [63:0] nd_data_out;

`ifdef PIPE_PERF_CNT_EN
    logic [15:0] perf_stall_cnt, perf_bubble_cnt;
    logic [15:0] nd_perf_stall_cnt, nd_perf_bubble_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(
        .DATA_W(32), .DATA_N(2), .CTRL_W(4), .TNEW_W(2), .TNEW_DEC(1),
        .PC_RESET(32'h0000_3000)
    ) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .valid_in(valid_in), .pc_in(pc_in), .reg_write_in(reg_write_in),
        .reg_dst_in(reg_dst_in), .tnew_in(tnew_in), .ctrl_in(ctrl_in),
        .data_in(data_in), .valid_out(valid_out), .pc_out(pc_out),
        .reg_write_out(reg_write_out), .reg_dst_out(reg_dst_out),
        .tnew_out(tnew_out), .ctrl_out(ctrl_out), .data_out(data_out),
`ifdef PIPE_PERF_CNT_EN
        .perf_stall_cnt(perf_stall_cnt), .perf_bubble_cnt(perf_bubble_cnt),
`endif
        .fwd_ready(fwd_ready)
    );

    pipe_stage_reg #(
        .DATA_W(32), .DATA_N(2), .CTRL_W(4), .TNEW_W(2), .TNEW_DEC(0),
        .PC_RESET(32'h0000_3000)
    ) dut_nd (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .valid_in(valid_in), .pc_in(pc_in), .reg_write_in(reg_write_in),
        .reg_dst_in(reg_dst_in), .tnew_in(tnew_in), .ctrl_in(ctrl_in),
        .data_in(data_in), .valid_out(nd_valid_out), .pc_out(nd_pc_out),
        .reg_write_out(nd_reg_write_out), .reg_dst_out(nd_reg_dst_out),
        .tnew_out(nd_tnew_out), .ctrl_out(nd_ctrl_out), .data_out(nd_data_out),
`ifdef PIPE_PERF_CNT_EN
        .perf_stall_cnt(nd_perf_stall_cnt), .perf_bubble_cnt(nd_perf_bubble_cnt),
`endif
        .fwd_ready(nd_fwd_ready)
    );

    typedef struct {
        logic        rst, stl, fl, v;
        logic [31:0] pc;
        logic        rw;
        logic [4:0]  dst;
        logic [1:0]  tn;
        logic [3:0]  ctl;
        logic [63:0] dat;
        logic        e_v;
        logic [31:0] e_pc;
        logic        e_rw;
        logic [4:0]  e_dst;
        logic [1:0]  e_tn;
        logic [3:0]  e_ctl;
        logic [63:0] e_dat;
        logic        e_fwd;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic stl, input logic fl, input logic v,
                         input logic [31:0] pc, input logic rw, input logic [4:0] dst,
                         input logic [1:0] tn, input logic [3:0] ctl, input logic [63:0] dat);
        reset = rst; stall = stl; flush = fl; valid_in = v; pc_in = pc;
        reg_write_in = rw; reg_dst_in = dst; tnew_in = tn; ctrl_in = ctl; data_in = dat;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Load vector: expected outputs are given explicitly per row.
    task automatic add(input logic rst, input logic stl, input logic fl, input logic v,
                       input logic [31:0] pc, input logic rw, input logic [4:0] dst,
                       input logic [1:0] tn, input logic [3:0] ctl, input logic [63:0] dat,
                       input logic e_v, input logic [31:0] e_pc, input logic e_rw,
                       input logic [4:0] e_dst, input logic [1:0] e_tn, input logic [3:0] e_ctl,
                       input logic [63:0] e_dat, input logic e_fwd);
        vec_t r;
        r.rst = rst; r.stl = stl; r.fl = fl; r.v = v; r.pc = pc; r.rw = rw; r.dst = dst;
        r.tn = tn; r.ctl = ctl; r.dat = dat; r.e_v = e_v; r.e_pc = e_pc; r.e_rw = e_rw;
        r.e_dst = e_dst; r.e_tn = e_tn; r.e_ctl = e_ctl; r.e_dat = e_dat; r.e_fwd = e_fwd;
        vecs.push_back(r);
    endtask

    initial begin
        drive(1, 0, 0, 0, 32'h0, 0, 5'd0, 2'd0, 4'h0, 64'h0);

        // Reset with garbage inputs.
        add(1,0,0,1, 32'h0000_1234,1,5'd7,2'd3,4'hF,64'hFFFF_FFFF_FFFF_FFFF,
            0,32'h0000_3000,0,5'd0,2'd0,4'h0,64'h0,0);
        // tnew 2 -> 1, not yet forwardable.
        add(0,0,0,1, 32'h0000_3004,1,5'd8,2'd2,4'h5,64'h1111_1111_DEAD_BEEF,
            1,32'h0000_3004,1,5'd8,2'd1,4'h5,64'h1111_1111_DEAD_BEEF,0);
        // tnew 1 -> 0, forwardable.
        add(0,0,0,1, 32'h0000_3008,1,5'd8,2'd1,4'hA,64'h0000_0002_CAFE_F00D,
            1,32'h0000_3008,1,5'd8,2'd0,4'hA,64'h0000_0002_CAFE_F00D,1);
        // tnew 0 saturates at 0.
        add(0,0,0,1, 32'h0000_300C,1,5'd9,2'd0,4'h3,64'h0000_0002_0000_0001,
            1,32'h0000_300C,1,5'd9,2'd0,4'h3,64'h0000_0002_0000_0001,1);
        // tnew 3 -> 2.
        add(0,0,0,1, 32'h0000_3010,1,5'd10,2'd3,4'h1,64'h0000_0000_0000_0042,
            1,32'h0000_3010,1,5'd10,2'd2,4'h1,64'h0000_0000_0000_0042,0);
        // Write to $0 never advertised.
        add(0,0,0,1, 32'h0000_3010,1,5'd0,2'd1,4'h2,64'h0000_0000_0000_0043,
            1,32'h0000_3010,0,5'd0,2'd0,4'h2,64'h0000_0000_0000_0043,0);
        // reg_write_in=0.
        add(0,0,0,1, 32'h0000_3012,0,5'd5,2'd0,4'h4,64'h0000_0000_0000_0044,
            1,32'h0000_3012,0,5'd5,2'd0,4'h4,64'h0000_0000_0000_0044,0);
        // Load before stall: tnew 2 -> 1.
        add(0,0,0,1, 32'h0000_3014,1,5'd8,2'd2,4'h6,64'h0000_BBBB_0000_AAAA,
            1,32'h0000_3014,1,5'd8,2'd1,4'h6,64'h0000_BBBB_0000_AAAA,0);
        // Three stalls with changing inputs: everything holds.
        for (int i = 0; i < 3; i++)
            add(0,1,0,i[0], 32'h0000_4000 + 32'(i*4),1,5'(3+i),2'(i),4'(9+i),64'(i) * 64'h0101_0101,
                1,32'h0000_3014,1,5'd8,2'd1,4'h6,64'h0000_BBBB_0000_AAAA,0);
        // Release: current inputs loaded.
        add(0,0,0,1, 32'h0000_3018,1,5'd3,2'd1,4'h7,64'h0000_0006_0000_0005,
            1,32'h0000_3018,1,5'd3,2'd0,4'h7,64'h0000_0006_0000_0005,1);
        // Flush together with stall.
        add(0,1,1,1, 32'h0000_3010,1,5'd4,2'd2,4'hF,64'h0000_0009_0000_0009,
            0,32'h0000_3010,0,5'd0,2'd0,4'h0,64'h0,0);
        // Load with valid_in=0 is a bubble with the incoming PC.
        add(0,0,0,0, 32'h0000_301C,1,5'd6,2'd2,4'h3,64'h7,
            0,32'h0000_301C,0,5'd0,2'd0,4'h0,64'h0,0);
        // Good load, then plain flush.
        add(0,0,0,1, 32'h0000_3020,1,5'd12,2'd0,4'hC,64'h0000_0000_1234_5678,
            1,32'h0000_3020,1,5'd12,2'd0,4'hC,64'h0000_0000_1234_5678,1);
        add(0,0,1,1, 32'h0000_3024,1,5'd12,2'd0,4'hC,64'h0000_0000_1234_5678,
            0,32'h0000_3024,0,5'd0,2'd0,4'h0,64'h0,0);
        // Reload, then reset while stall and flush are both asserted.
        add(0,0,0,1, 32'h0000_3028,1,5'd13,2'd0,4'hD,64'h55,
            1,32'h0000_3028,1,5'd13,2'd0,4'hD,64'h55,1);
        add(1,1,1,1, 32'h0000_302C,1,5'd14,2'd2,4'hE,64'h66,
            0,32'h0000_3000,0,5'd0,2'd0,4'h0,64'h0,0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].stl, vecs[i].fl, vecs[i].v, vecs[i].pc, vecs[i].rw,
                  vecs[i].dst, vecs[i].tn, vecs[i].ctl, vecs[i].dat);
            step();
            check($sformatf("v%0d valid_out", i), 64'(valid_out), 64'(vecs[i].e_v));
            check($sformatf("v%0d pc_out", i), 64'(pc_out), 64'(vecs[i].e_pc));
            check($sformatf("v%0d reg_write_out", i), 64'(reg_write_out), 64'(vecs[i].e_rw));
            check($sformatf("v%0d reg_dst_out", i), 64'(reg_dst_out), 64'(vecs[i].e_dst));
            check($sformatf("v%0d tnew_out", i), 64'(tnew_out), 64'(vecs[i].e_tn));
            check($sformatf("v%0d ctrl_out", i), 64'(ctrl_out), 64'(vecs[i].e_ctl));
            check($sformatf("v%0d data_out", i), data_out, vecs[i].e_dat);
            check($sformatf("v%0d fwd_ready", i), 64'(fwd_ready), 64'(vecs[i].e_fwd));
        end

        // TNEW_DEC=0 instance: Tnew passes through unchanged.
        drive(0,0,0,1, 32'h0000_3100,1,5'd7,2'd2,4'h1,64'hABCD);
        step();
        check("nd valid_out", 64'(nd_valid_out), 64'd1);
        check("nd pc_out", 64'(nd_pc_out), 64'h3100);
        check("nd reg_write_out", 64'(nd_reg_write_out), 64'd1);
        check("nd reg_dst_out", 64'(nd_reg_dst_out), 64'd7);
        check("nd tnew_out pass 2", 64'(nd_tnew_out), 64'd2);
        check("nd ctrl_out", 64'(nd_ctrl_out), 64'h1);
        check("nd data_out", nd_data_out, 64'hABCD);
        check("nd fwd_ready tnew2", 64'(nd_fwd_ready), 64'd0);
        drive(0,0,0,1, 32'h0000_3104,1,5'd7,2'd0,4'h1,64'hABCD);
        step();
        check("nd tnew_out pass 0", 64'(nd_tnew_out), 64'd0);
        check("nd fwd_ready tnew0", 64'(nd_fwd_ready), 64'd1);

`ifdef PIPE_PERF_CNT_EN
        drive(1,0,0,1, 32'h0,0,5'd0,2'd0,4'h0,64'h0);
        step();
        check("perf stall after reset", 64'(perf_stall_cnt), 64'd0);
        check("perf bubble after reset", 64'(perf_bubble_cnt), 64'd0);
        for (int i = 0; i < 5; i++) begin
            drive(0,1,0,1, 32'h0000_3200,1,5'd1,2'd0,4'h0,64'h0);
            step();
        end
        for (int i = 0; i < 2; i++) begin
            drive(0,0,1,1, 32'h0000_3204,1,5'd1,2'd0,4'h0,64'h0);
            step();
        end
        check("perf_stall_cnt 5", 64'(perf_stall_cnt), 64'd5);
        check("perf_bubble_cnt 2", 64'(perf_bubble_cnt), 64'd2);
        drive(0,0,0,0, 32'h0000_3208,1,5'd1,2'd0,4'h0,64'h0);
        step();
        check("perf_bubble_cnt invalid load", 64'(perf_bubble_cnt), 64'd3);
        check("perf_stall_cnt held", 64'(perf_stall_cnt), 64'd5);
        drive(1,1,0,1, 32'h0000_320C,1,5'd1,2'd0,4'h0,64'h0);
        step();
        check("perf_stall_cnt mid reset", 64'(perf_stall_cnt), 64'd0);
        check("perf_bubble_cnt mid reset", 64'(perf_bubble_cnt), 64'd0);
        check("nd perf_stall_cnt mid reset", 64'(nd_perf_stall_cnt), 64'd0);
        check("nd perf_bubble_cnt mid reset", 64'(nd_perf_bubble_cnt), 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
